text_fetch: RTL and testbench
=============================

TEXT_FETCH -- requirements
Module: text_fetch

Interface
REQ-001 Parameters SHALL be, one per line:
- COLUMNS, 80, characters per text row.
- ROWS, 48, text rows per frame.
- CHAR_HEIGHT, 10, pixel lines per character cell.
- BLANK_INDEX, 8'h20, glyph substituted for hidden blinking characters.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- active  in  1  visible pixel this cycle.
- new_line  in  1  one-cycle strobe in blanking, before each pixel line.
- new_frame  in  1  one-cycle strobe in vertical blanking, before the first line.
- text_addr  out  12  text RAM read address.
- text_data  in  16  RAM word, valid one cycle after text_addr. Bits: [7:0] char index, [8] underline, [9] invert, [10] blink.
- xchar  out  3  pixel column within the cell.
- ychar  out  4  pixel line within the cell.
- character_index  out  8  glyph index to the character generator.
- underline  out  1  underline attribute.
- invert  out  1  invert attribute.
- pixel_valid  out  1  outputs describe a visible pixel.

Function
REQ-003 The block SHALL keep these internal counters: xcnt (3b), col (7b), ycnt (4b), row (6b), frame_cnt (6b).
REQ-004 Counter update priority SHALL be new_frame > new_line > active.
REQ-005 new_frame SHALL:
- clear xcnt, col, ycnt and row;
- increment frame_cnt, wrapping 63->0.
REQ-006 new_line, when new_frame is low, SHALL clear xcnt and col. It SHALL also:
- increment ycnt;
- when ycnt == CHAR_HEIGHT-1, wrap ycnt to 0 and increment row;
- wrap row from ROWS-1 to 0.
REQ-007 active, when both strobes are low, SHALL increment xcnt. On xcnt 7->0, col SHALL increment, and col SHALL wrap from COLUMNS-1 to 0.
REQ-008 When active is asserted together with either strobe, that pixel SHALL NOT advance the counters, and pixel_valid SHALL be 0 for it two cycles later.
REQ-009 text_addr SHALL be combinational: row*COLUMNS + col from the current counters.
- Width: 12 bits.
- Max value: 3839 at the default parameters.
REQ-010 Stage 1 SHALL register xcnt, ycnt and the qualified active bit (active AND no strobe) once, alongside the RAM read.
REQ-011 Stage 2 SHALL register all outputs from stage 1 and text_data. Fixed latency: 2 cycles from the active sample to pixel_valid/xchar/ychar/character_index.
REQ-012 blink_phase SHALL equal frame_cnt[5]. This gives a 32-frames-on / 32-frames-off cycle.
REQ-013 If text_data[10]=1 and blink_phase=1:
- character_index SHALL be BLANK_INDEX;
- underline SHALL be 0;
- invert SHALL still be text_data[9].
Otherwise the outputs SHALL equal text_data fields directly.
REQ-014 When pixel_valid=0, character_index, underline and invert SHALL hold their previous values. xchar and ychar SHALL still follow the pipeline.
REQ-015 The block SHALL accept back-to-back active cycles indefinitely with no stall. No handshake back-pressure SHALL exist.

Reset
REQ-016 When reset=1 at a rising edge, all of the following SHALL be 0 after that edge: counters, frame_cnt, both pipeline stages, and every registered output.
REQ-017 text_addr SHALL read 0 in the cycle after reset.
REQ-018 reset SHALL have priority over new_frame, new_line and active.
REQ-019 reset asserted mid-line SHALL discard both in-flight pipeline stages. pixel_valid SHALL be 0 for the 2 cycles after reset deasserts, even if active is held high.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Latency: reset, new_frame, new_line, then active high for 16 cycles with RAM word 0 = 16'h0141, word 1 = 16'h0242 -> pixel_valid rises 2 cycles after the first active. Then xchar 0..7 with character_index 8'h41, underline 1, invert 0, followed by xchar 0..7 with 8'h42, underline 0, invert 1. text_addr steps 0 -> 1.
- Cell wrap: CHAR_HEIGHT=10 new_line strobes without new_frame -> on the 10th, ycnt 9 -> 0 and row 0 -> 1. The next line's first text_addr = 80.
- Frame wrap: run to row 47, ycnt 9, then new_line -> row 0. new_frame -> all counters 0 and frame_cnt +1.
- Blink: word 0 = 16'h0441 -> character_index 8'h41 for frame_cnt 0..31, and 8'h20 with underline 0 for frame_cnt 32..63. Back to 8'h41 at frame_cnt wrap.
- Collision: active=1 together with new_line -> no counter advance, and that pixel's pixel_valid = 0 two cycles later.
- Reset mid-line: reset pulsed at col 5, xcnt 3, with active held high -> pixel_valid 0 for 2 cycles after deassert. The first valid pixel has xchar 0 and text_addr 0.

Source files
------------

// File: rtl/text_fetch.sv
// Character-cell text fetch: walks the text RAM in raster order and delivers
// per-pixel glyph index, cell coordinates and attributes two cycles after the pixel.
module text_fetch #(
    parameter int          COLUMNS     = 80,
    parameter int          ROWS        = 48,
    parameter int          CHAR_HEIGHT = 10,
    parameter logic [7:0]  BLANK_INDEX = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic        new_line,
    input  logic        new_frame,
    output logic [11:0] text_addr,
    input  logic [15:0] text_data,
    output logic [2:0]  xchar,
    output logic [3:0]  ychar,
    output logic [7:0]  character_index,
    output logic        underline,
    output logic        invert,
    output logic        pixel_valid
);

    localparam logic [11:0] COLS_W   = 12'(COLUMNS);
    localparam logic [6:0]  COL_LAST = 7'(COLUMNS - 1);
    localparam logic [5:0]  ROW_LAST = 6'(ROWS - 1);
    localparam logic [3:0]  Y_LAST   = 4'(CHAR_HEIGHT - 1);

    logic [2:0] xcnt_q, xcnt_d;
    logic [6:0] col_q, col_d;
    logic [3:0] ycnt_q, ycnt_d;
    logic [5:0] row_q, row_d;
    logic [5:0] frame_q, frame_d;

    logic       s1_valid_q;
    logic [2:0] s1_x_q;
    logic [3:0] s1_y_q;

    logic       valid_q;
    logic [2:0] xchar_q;
    logic [3:0] ychar_q;
    logic [7:0] char_q;
    logic       ul_q;
    logic       inv_q;

    logic pix_adv;
    logic hide;

    // A pixel coinciding with either strobe is dropped, not queued.
    assign pix_adv = active & ~new_line & ~new_frame;
    assign hide    = text_data[10] & frame_q[5];

    always_comb begin
        xcnt_d  = xcnt_q;
        col_d   = col_q;
        ycnt_d  = ycnt_q;
        row_d   = row_q;
        frame_d = frame_q;
        if (new_frame) begin
            xcnt_d  = '0;
            col_d   = '0;
            ycnt_d  = '0;
            row_d   = '0;
            frame_d = frame_q + 6'd1;
        end else if (new_line) begin
            xcnt_d = '0;
            col_d  = '0;
            if (ycnt_q == Y_LAST) begin
                ycnt_d = '0;
                row_d  = (row_q == ROW_LAST) ? '0 : row_q + 6'd1;
            end else begin
                ycnt_d = ycnt_q + 4'd1;
            end
        end else if (active) begin
            xcnt_d = xcnt_q + 3'd1;
            if (xcnt_q == 3'd7) begin
                col_d = (col_q == COL_LAST) ? '0 : col_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xcnt_q  <= '0;
            col_q   <= '0;
            ycnt_q  <= '0;
            row_q   <= '0;
            frame_q <= '0;
        end else begin
            xcnt_q  <= xcnt_d;
            col_q   <= col_d;
            ycnt_q  <= ycnt_d;
            row_q   <= row_d;
            frame_q <= frame_d;
        end
    end

    assign text_addr = {6'd0, row_q} * COLS_W + {5'd0, col_q};

    // Stage 1 runs alongside the RAM read; stage 2 captures the returned word.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            valid_q    <= 1'b0;
            xchar_q    <= '0;
            ychar_q    <= '0;
            char_q     <= '0;
            ul_q       <= 1'b0;
            inv_q      <= 1'b0;
        end else begin
            s1_valid_q <= pix_adv;
            s1_x_q     <= xcnt_q;
            s1_y_q     <= ycnt_q;
            valid_q    <= s1_valid_q;
            xchar_q    <= s1_x_q;
            ychar_q    <= s1_y_q;
            if (s1_valid_q) begin
                char_q <= hide ? BLANK_INDEX : text_data[7:0];
                ul_q   <= text_data[8] & ~hide;
                inv_q  <= text_data[9];
            end
        end
    end

    assign pixel_valid     = valid_q;
    assign xchar           = xchar_q;
    assign ychar           = ychar_q;
    assign character_index = char_q;
    assign underline       = ul_q;
    assign invert          = inv_q;

endmodule

// File: tb/tb_text_fetch.sv
// Scoreboarded bench for text_fetch: a counter model predicts each pixel's
// outputs when it is driven; they are compared when the pipeline delivers them.
module tb_text_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        active = 1'b0;
    logic        new_line = 1'b0;
    logic        new_frame = 1'b0;
    logic [11:0] text_addr;
    logic [15:0] text_data = '0;
    logic [2:0]  xchar;
    logic [3:0]  ychar;
    logic [7:0]  character_index;
    logic        underline;
    logic        invert;
    logic        pixel_valid;

    text_fetch #(
        .COLUMNS(80),
        .ROWS(48),
        .CHAR_HEIGHT(10),
        .BLANK_INDEX(8'h20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .active(active),
        .new_line(new_line),
        .new_frame(new_frame),
        .text_addr(text_addr),
        .text_data(text_data),
        .xchar(xchar),
        .ychar(ychar),
        .character_index(character_index),
        .underline(underline),
        .invert(invert),
        .pixel_valid(pixel_valid)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:4095];
    always @(posedge clk) text_data <= mem[text_addr];

    typedef struct {
        bit         v;
        logic [2:0] x;
        logic [3:0] y;
        logic [7:0] c;
        bit         u;
        bit         i;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_err = 0;

    int m_x, m_col, m_y, m_row, m_frame;
    logic [7:0] last_c;
    bit         last_u, last_i;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_out(input exp_t e);
        check("pixel_valid", int'(pixel_valid), int'(e.v));
        check("xchar", int'(xchar), int'(e.x));
        check("ychar", int'(ychar), int'(e.y));
        if (e.v) begin
            last_c = e.c;
            last_u = e.u;
            last_i = e.i;
        end
        check("character_index", int'(character_index), int'(last_c));
        check("underline", int'(underline), int'(last_u));
        check("invert", int'(invert), int'(last_i));
    endtask

    task automatic step(input bit a, input bit nl, input bit nf, input bit rst);
        exp_t        e;
        exp_t        o;
        logic [15:0] w;
        bit          blink;
        @(negedge clk);
        active    = a;
        new_line  = nl;
        new_frame = nf;
        reset     = rst;
        w     = mem[m_row * 80 + m_col];
        blink = w[10] && (m_frame >= 32);
        e.v = a && !nl && !nf && !rst;
        e.x = rst ? 3'd0 : 3'(m_x);
        e.y = rst ? 4'd0 : 4'(m_y);
        e.c = blink ? 8'h20 : w[7:0];
        e.u = w[8] && !blink;
        e.i = w[9];
        @(posedge clk);
        if (rst) begin
            m_x = 0; m_col = 0; m_y = 0; m_row = 0; m_frame = 0;
        end else if (nf) begin
            m_x = 0; m_col = 0; m_y = 0; m_row = 0;
            m_frame = (m_frame + 1) % 64;
        end else if (nl) begin
            m_x = 0; m_col = 0;
            if (m_y == 9) begin
                m_y = 0;
                m_row = (m_row == 47) ? 0 : m_row + 1;
            end else begin
                m_y = m_y + 1;
            end
        end else if (a) begin
            if (m_x == 7) begin
                m_x = 0;
                m_col = (m_col == 79) ? 0 : m_col + 1;
            end else begin
                m_x = m_x + 1;
            end
        end
        #1;
        if (rst) begin
            q.delete();
            last_c = '0; last_u = 0; last_i = 0;
            o.v = 0; o.x = '0; o.y = '0; o.c = '0; o.u = 0; o.i = 0;
            compare_out(o);
            q.push_back(e);
        end else begin
            q.push_back(e);
            if (q.size() >= 2) begin
                o = q.pop_front();
                compare_out(o);
            end
        end
        check("text_addr", int'(text_addr), m_row * 80 + m_col);
    endtask

    task automatic run_active(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) mem[k] = '0;
        m_x = 0; m_col = 0; m_y = 0; m_row = 0; m_frame = 0;
        last_c = '0; last_u = 0; last_i = 0;

        // Latency and first two cells
        mem[0] = 16'h0141;
        mem[1] = 16'h0242;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        run_active(8);
        check("addr_after_cell0", int'(text_addr), 1);
        run_active(8);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Column wrap across a full line
        run_active(640 - 16);
        check("addr_col_wrap", int'(text_addr), 0);
        step(0, 0, 0, 0);

        // Cell wrap: 10 line strobes move to row 1
        step(0, 0, 1, 0);
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0);
        check("addr_row1", int'(text_addr), 80);
        mem[80] = 16'h0355;
        run_active(10);
        step(0, 0, 0, 0);

        // Collision of active with new_line / new_frame
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Frame wrap: row 47 / ycnt 9, then one more line returns to row 0
        for (int k = 0; k < 479; k++) step(0, 1, 0, 0);
        check("addr_row47", int'(text_addr), 3760);
        mem[3760] = 16'h0277;
        run_active(3);
        step(0, 1, 0, 0);
        check("addr_row_wrap", int'(text_addr), 0);
        run_active(3);
        step(0, 0, 1, 0);
        check("addr_new_frame", int'(text_addr), 0);
        step(0, 0, 0, 0);

        // Reset mid-line at col 5, xcnt 3 with active held high
        step(0, 1, 0, 0);
        run_active(43);
        check("addr_col5", int'(text_addr), 5);
        step(1, 0, 0, 1);
        check("addr_after_reset", int'(text_addr), 0);
        run_active(12);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Blink through all 64 frames and back round the wrap
        mem[0] = 16'h0441;
        step(0, 0, 0, 1);
        for (int f = 0; f < 66; f++) begin
            step(0, 1, 0, 0);
            run_active(8);
            step(0, 0, 0, 0);
            step(0, 0, 0, 0);
            step(0, 0, 1, 0);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
